// File: rtl/bus_interconnect_mux_pkg.sv
// Shared definitions for the bus interconnect: FSM state encoding, counter
// width, error data value and the slave-index width helper.
package bus_interconnect_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CNT_W    = 8;
  localparam int ERR_DATA = 0;

  // A single-slave map still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_interconnect_mux_decoder.sv
// Combinational mask/base address decoder; the lowest matching slave index
// wins when regions overlap.
module bus_addr_decoder
  import bus_interconnect_mux_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter int                         ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                         IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] match,
  output logic [IDX_W-1:0]      idx
);

  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match[i] = ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]);
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = i[IDX_W-1:0];
    end
    hit = |match;
  end

endmodule

// File: rtl/bus_interconnect_mux.sv
// Single-master, N-slave interconnect: registered request/response handshake
// with slave wait states, decode-miss, timeout and illegal-request errors.
module bus_interconnect_mux
  import bus_interconnect_mux_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h8000_0100, 32'h8000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000, 32'hF000_0000},
  parameter int                           TIMEOUT    = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         proc_rd_en_i,
  input  logic                         proc_wr_en_i,
  input  logic [ADDR_W-1:0]            proc_addr_i,
  input  logic [DATA_W-1:0]            proc_data_i,
  output logic [DATA_W-1:0]            proc_data_o,
  output logic                         proc_ready_o,
  output logic                         proc_err_o,
  output logic [NUM_SLAVES-1:0]        slv_rd_en_o,
  output logic [NUM_SLAVES-1:0]        slv_wr_en_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W-1:0]            slv_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_data_i,
  input  logic [NUM_SLAVES-1:0]        slv_ready_i
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        sel;
  logic                    op_wr;

  logic                    dec_hit;
  logic [NUM_SLAVES-1:0]   dec_match;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;

  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_data;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr  (proc_addr_i),
    .hit   (dec_hit),
    .match (dec_match),
    .idx   (dec_idx)
  );

  // Keep only the lowest set bit so overlapping regions strobe a single slave.
  assign dec_onehot = dec_match & ~(dec_match - NUM_SLAVES'(1));

  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == i[IDX_W-1:0]) begin
        sel_ready = slv_ready_i[i];
        sel_data  = slv_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      cnt          <= '0;
      sel          <= '0;
      op_wr        <= 1'b0;
      slv_addr_o   <= '0;
      slv_data_o   <= '0;
      slv_rd_en_o  <= '0;
      slv_wr_en_o  <= '0;
      proc_data_o  <= '0;
      proc_ready_o <= 1'b0;
      proc_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          proc_ready_o <= 1'b0;
          if (proc_rd_en_i && proc_wr_en_i) begin
            state        <= RESP;
            proc_ready_o <= 1'b1;
            proc_err_o   <= 1'b1;
            proc_data_o  <= DATA_W'(ERR_DATA);
          end else if (proc_rd_en_i || proc_wr_en_i) begin
            slv_addr_o <= proc_addr_i;
            slv_data_o <= proc_data_i;
            op_wr      <= proc_wr_en_i;
            sel        <= dec_idx;
            cnt        <= '0;
            if (dec_hit) begin
              state <= ACCESS;
              if (proc_wr_en_i) slv_wr_en_o <= dec_onehot;
              else              slv_rd_en_o <= dec_onehot;
            end else begin
              state        <= RESP;
              proc_ready_o <= 1'b1;
              proc_err_o   <= 1'b1;
              proc_data_o  <= DATA_W'(ERR_DATA);
            end
          end
        end
        ACCESS: begin
          // A ready in the final counted cycle still beats the timeout.
          if (sel_ready) begin
            state        <= RESP;
            slv_rd_en_o  <= '0;
            slv_wr_en_o  <= '0;
            proc_ready_o <= 1'b1;
            proc_err_o   <= 1'b0;
            proc_data_o  <= op_wr ? DATA_W'(ERR_DATA) : sel_data;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              state        <= RESP;
              slv_rd_en_o  <= '0;
              slv_wr_en_o  <= '0;
              proc_ready_o <= 1'b1;
              proc_err_o   <= 1'b1;
              proc_data_o  <= DATA_W'(ERR_DATA);
            end
          end
        end
        RESP: begin
          proc_ready_o <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          proc_ready_o <= 1'b0;
          slv_rd_en_o  <= '0;
          slv_wr_en_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect_mux.sv
// Directed-vector bench for bus_interconnect_mux using the default 4-slave map.
module tb_bus_interconnect_mux;

  logic         clk;
  logic         rst_n;
  logic         proc_rd_en;
  logic         proc_wr_en;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_ready;
  logic         proc_err;
  logic [3:0]   slv_rd_en;
  logic [3:0]   slv_wr_en;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;

  int n_vec = 0;
  int n_err = 0;

  bus_interconnect_mux dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .proc_rd_en_i (proc_rd_en),
    .proc_wr_en_i (proc_wr_en),
    .proc_addr_i  (proc_addr),
    .proc_data_i  (proc_wdata),
    .proc_data_o  (proc_rdata),
    .proc_ready_o (proc_ready),
    .proc_err_o   (proc_err),
    .slv_rd_en_o  (slv_rd_en),
    .slv_wr_en_o  (slv_wr_en),
    .slv_addr_o   (slv_addr),
    .slv_data_o   (slv_wdata),
    .slv_data_i   (slv_rdata),
    .slv_ready_i  (slv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one transaction. Called one step after a rising edge with the DUT in IDLE.
  // ready_at: cycle in which the selected slave raises ready (-1 = never).
  // noise: ready bits driven on the other slaves throughout.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int slv, input int ready_at, input logic [3:0] noise,
                     input logic [31:0] rdata,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_data,
                     input int exp_strb, input logic [3:0] exp_mask);
    int cyc, strb, lat;
    logic got;
    logic [31:0] d, a_seen, w_seen;
    logic e;
    logic [3:0] mask;
    got = 1'b0; lat = 0; strb = 0; mask = '0; d = '0; e = 1'b0;
    a_seen = '0; w_seen = '0;
    for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = rdata + 32'(i);
    proc_rd_en = rd; proc_wr_en = wr; proc_addr = addr; proc_wdata = wdata;
    @(posedge clk); #1;
    proc_rd_en = 1'b0; proc_wr_en = 1'b0; proc_addr = '0; proc_wdata = '0;
    cyc = 1;
    while (cyc <= 40 && !got) begin
      if (proc_ready) begin
        got = 1'b1; lat = cyc; d = proc_rdata; e = proc_err;
      end
      if ((slv_rd_en | slv_wr_en) != 4'b0) begin
        if (strb == 0) begin a_seen = slv_addr; w_seen = slv_wdata; end
        strb++;
        mask = mask | slv_rd_en | slv_wr_en;
      end
      slv_ready = noise;
      if (slv >= 0 && cyc == ready_at) slv_ready[slv] = 1'b1;
      if (!got) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    slv_ready = '0;
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_err"},  {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_strb"}, 32'(strb), 32'(exp_strb));
    chk({tag, "_mask"}, {28'b0, mask}, {28'b0, exp_mask});
    if (exp_strb > 0) begin
      chk({tag, "_addr"}, a_seen, addr);
      chk({tag, "_wdat"}, w_seen, wdata);
    end
    // Move into IDLE; the completion pulse must be gone.
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, proc_ready}, 32'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    proc_rd_en = 1'b0; proc_wr_en = 1'b0; proc_addr = '0; proc_wdata = '0;
    slv_rdata = '0; slv_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {proc_rdata[15:0], 7'b0, proc_ready, proc_err, slv_rd_en, slv_wr_en}, 32'd0);
    chk("rst_addr", slv_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   tag     rd    wr    addr          wdata         slv ready noise  rdata          lat err  data          strb mask
    txn("rd0",   1'b1, 1'b0, 32'h0000_0040, 32'h0,        0,  1,  4'b0000, 32'h1234_5678, 2, 1'b0, 32'h1234_5678, 1,  4'b0001);
    txn("wr2",   1'b0, 1'b1, 32'h8000_0004, 32'h0000_00FF, 2,  4,  4'b0000, 32'hDEAD_0000, 5, 1'b0, 32'h0,         4,  4'b0100);
    txn("miss",  1'b1, 1'b0, 32'h4000_0000, 32'h0,        -1, -1, 4'b1111, 32'hBEEF_0000, 1, 1'b1, 32'h0,         0,  4'b0000);
    txn("tmo",   1'b1, 1'b0, 32'h1000_0000, 32'h0,        1, -1, 4'b1101, 32'hCAFE_0000, 16, 1'b1, 32'h0,        15, 4'b0010);
    txn("tmo_rdy", 1'b1, 1'b0, 32'h1000_0000, 32'h0,      1, 15, 4'b0000, 32'h55AA_0000, 16, 1'b0, 32'h55AA_0001, 15, 4'b0010);
    txn("illeg", 1'b1, 1'b1, 32'h0000_0040, 32'h0,        -1, -1, 4'b0000, 32'h1111_0000, 1, 1'b1, 32'h0,         0,  4'b0000);
    txn("rd3",   1'b1, 1'b0, 32'h8000_0104, 32'h0,        3,  2,  4'b0000, 32'hA000_0000, 3, 1'b0, 32'hA000_0003, 2,  4'b1000);
    txn("miss2", 1'b0, 1'b1, 32'h8000_0204, 32'h1234,     -1, -1, 4'b0000, 32'h0,        1, 1'b1, 32'h0,         0,  4'b0000);

    // Reset in the middle of an ACCESS to slave 1 that never answers.
    proc_rd_en = 1'b1; proc_addr = 32'h1000_0010;
    @(posedge clk); #1;
    proc_rd_en = 1'b0; proc_addr = '0;
    @(posedge clk); #1;
    chk("pre_rst_strb", {28'b0, slv_rd_en}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strb", {24'b0, slv_rd_en, slv_wr_en}, 32'd0);
    chk("mid_rst_addr", slv_addr, 32'd0);
    chk("mid_rst_resp", {30'b0, proc_ready, proc_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (proc_ready || slv_rd_en != 4'b0) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
